// File: rtl/mont_pow_engine.sv
// Constant-time modular exponentiator (left-to-right square-and-multiply) in the
// Montgomery domain, driving one single-cycle REDC multiplier per clock.
module mont_pow_engine #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] MOD    = 998244353,
  parameter logic [WIDTH-1:0] NPRIME = 998244351,
  parameter logic [WIDTH-1:0] R2     = 932051910
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int               W2    = 2 * WIDTH;
  localparam int               IDX_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE, CONV_X, CONV_ONE, SQR, MUL, EXIT, DONE
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   base_q, exp_q, xbar, acc;
  logic [IDX_W-1:0]   idx;

  logic [WIDTH-1:0]   op_a, op_b;
  logic [W2-1:0]      redc_t, redc_mn;
  logic [W2:0]        redc_sum;
  logic [WIDTH:0]     redc_u;
  logic [WIDTH-1:0]   redc_m, redc_out;

  // ---------------------------------------------------------------- FSM
  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (in_valid) state_nxt = CONV_X;
      CONV_X:   state_nxt = CONV_ONE;
      CONV_ONE: state_nxt = SQR;
      SQR:      state_nxt = MUL;
      MUL:      state_nxt = (idx == '0) ? EXIT : SQR;
      EXIT:     state_nxt = DONE;
      DONE:     if (out_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  // ---------------------------------------------------------- REDC operands
  // The multiplier is exercised in every working state, including MUL when the
  // exponent bit is clear, so the schedule never depends on the exponent.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      CONV_X:   begin op_a = base_q; op_b = R2;   end
      CONV_ONE: begin op_a = ONE;    op_b = R2;   end
      SQR:      begin op_a = acc;    op_b = acc;  end
      MUL:      begin op_a = acc;    op_b = xbar; end
      EXIT:     begin op_a = acc;    op_b = ONE;  end
      default:  begin op_a = '0;     op_b = '0;   end
    endcase
  end

  // Montgomery reduction: (a*b + m*MOD) / R with the carry bit kept, then one
  // conditional subtraction brings the value below MOD.
  always_comb begin
    redc_t   = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
    redc_m   = redc_t[WIDTH-1:0] * NPRIME;
    redc_mn  = {{WIDTH{1'b0}}, redc_m} * {{WIDTH{1'b0}}, MOD};
    redc_sum = {1'b0, redc_t} + {1'b0, redc_mn};
    redc_u   = (WIDTH+1)'(redc_sum >> WIDTH);
    redc_out = (redc_u >= {1'b0, MOD}) ? WIDTH'(redc_u - {1'b0, MOD})
                                       : redc_u[WIDTH-1:0];
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      exp_q  <= '0;
      xbar   <= '0;
      acc    <= '0;
      idx    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          base_q <= base;
          exp_q  <= exp;
          idx    <= IDX_W'(WIDTH - 1);
        end
        CONV_X:   xbar <= redc_out;
        CONV_ONE: acc  <= redc_out;
        SQR:      acc  <= redc_out;
        MUL: begin
          if (exp_q[idx]) acc <= redc_out;
          if (idx != '0)  idx <= idx - 1'b1;
        end
        EXIT:     result <= redc_out;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_pow_engine.sv
// Scoreboard bench for mont_pow_engine: stimulus pushes expected pow-mod results,
// a monitor pops and compares on every output handshake.
module tb_mont_pow_engine;

  localparam int              WIDTH = 32;
  localparam longint unsigned MOD_L = 998244353;
  localparam int              LAT   = 2 * WIDTH + 3;

  logic             clk, rst_n;
  logic             in_valid, in_ready, out_valid, out_ready, busy;
  logic [WIDTH-1:0] base, exp, result;

  int              checks = 0;
  int              errors = 0;
  longint unsigned sb[$];

  mont_pow_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .base      (base),
    .exp       (exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Plain right-to-left binary exponentiation with ordinary modular arithmetic.
  function automatic longint unsigned pow_mod(input longint unsigned b, input longint unsigned e);
    longint unsigned r = 1;
    longint unsigned x = b % MOD_L;
    while (e != 0) begin
      if (e[0]) r = (r * x) % MOD_L;
      x = (x * x) % MOD_L;
      e = e >> 1;
    end
    return r % MOD_L;
  endfunction

  // Monitor: one comparison per output handshake.
  always @(negedge clk) begin : monitor
    longint unsigned req;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result %0d, expected no output", result);
      end else begin
        req = sb.pop_front();
        check("result", {32'd0, result}, req);
      end
    end
  end

  // Issue one job and follow it through to its output handshake.
  // hold > 0 stalls out_ready for that many cycles in DONE; pulse drives
  // in_valid with junk while the engine is busy.
  task automatic run_job(input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] e,
                         input bit pulse, input int hold, input bit chk_lat);
    int w   = 0;
    int lat = 0;
    logic [WIDTH-1:0] held;
    while (in_ready !== 1'b1 && w < 300) begin
      @(posedge clk); #1; w++;
    end
    check("in_ready_wait", {63'd0, (w < 300)}, 64'd1);
    in_valid  = 1'b1;
    base      = b;
    exp       = e;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    base     = $urandom;
    exp      = $urandom;
    sb.push_back(pow_mod(b, e));
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
      in_valid = pulse && (lat % 5 == 2);
      base     = $urandom;
      exp      = $urandom;
    end
    in_valid = 1'b0;
    if (chk_lat) check("latency", lat, LAT);
    if (hold > 0) begin
      held = result;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_result", {32'd0, result}, {32'd0, held});
      end
      out_ready = 1'b1;
    end
    check("ready_in_done", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    check("ready_after_hs", {63'd0, in_ready}, 64'd1);
    check("valid_after_hs", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    base      = '0;
    exp       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases, including exponent and base boundaries.
    run_job(32'd5, 32'd0, 1'b0, 0, 1'b1);
    run_job(32'd2, 32'd10, 1'b0, 0, 1'b1);
    run_job(32'd998244352, 32'd3, 1'b0, 0, 1'b1);
    run_job(32'd0, 32'd0, 1'b0, 0, 1'b1);
    run_job(32'd0, 32'd7, 1'b0, 0, 1'b1);
    run_job(32'd3, 32'd998244352, 1'b0, 0, 1'b1);
    run_job(32'd3, 32'hFFFF_FFFF, 1'b0, 0, 1'b1);
    check("fermat_model", pow_mod(3, 998244352), 64'd1);

    // Backpressure in DONE with junk in_valid pulses while busy.
    run_job(32'd123456789, 32'hDEAD_BEEF, 1'b1, 10, 1'b1);

    // Reset in the middle of a job aborts it with no output.
    in_valid = 1'b1;
    base     = 32'd7;
    exp      = 32'h1234_5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("mid_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_result", {32'd0, result}, 64'd0);
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(32'd2, 32'd10, 1'b0, 0, 1'b1);

    // Randomized back-to-back jobs against the reference model.
    for (int i = 0; i < 1000; i++) begin
      logic [WIDTH-1:0] b, e;
      b = WIDTH'($urandom % 32'(MOD_L));
      e = $urandom;
      if (i % 4 == 1) e = $urandom_range(0, 20);
      if (i % 97 == 5) b = '0;
      run_job(b, e, (i % 10 == 3), (i % 50 == 7) ? 3 : 0, (i % 8 == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
